sad_search_ctrl: RTL and testbench

Sequencer for the absolute-difference accumulator (afd) in block-matching motion search. It walks N_CAND candidate blocks of N_PAIRS pixel-pair reads each, and generates the read addresses for the original-block and candidate-block memories. It drives afd en/acum aligned with the memory read data, captures each candidate's final SAD and tracks the minimum SAD and its candidate index. Pixel data flows from the memories straight into afd; this block handles control and result handling only.

---
 rtl/sad_pkg.sv | 26 ++
 rtl/sad_search_ctrl_if.sv | 43 ++++
 rtl/sad_min_tracker.sv | 45 ++++
 rtl/sad_search_ctrl.sv | 130 +++++++++++++
 tb/tb_sad_search_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sad_pkg.sv
// Shared types and constants for the SAD block-matching search controller
// and the blocks that reuse its minimum tracker.
package sad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    COMPARE,
    DONE
  } sad_state_e;

  // Memory read latency and afd pipeline depth; DRAIN lasts AFD_LAT cycles.
  localparam int MEM_LAT = 1;
  localparam int AFD_LAT = 2;

  function automatic int sad_width(input int width);
    return width + 8;
  endfunction

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sad_search_ctrl_if.sv
// Control/result bundle between the SAD search sequencer and its
// surroundings: memories, afd accumulator and result consumer.
interface sad_search_ctrl_if
  import sad_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int N_PAIRS = 8,
  parameter int N_CAND  = 4
) ();

  localparam int SW = sad_width(WIDTH);
  localparam int OW = idx_width(N_PAIRS);
  localparam int CW = idx_width(N_CAND * N_PAIRS);
  localparam int IW = idx_width(N_CAND);

  logic          start;
  logic          mem_rd;
  logic [OW-1:0] addr_orig;
  logic [CW-1:0] addr_cand;
  logic          afd_en;
  logic          afd_acum;
  logic [SW-1:0] afd_sad;
  logic          sad_valid;
  logic [SW-1:0] sad_value;
  logic [IW-1:0] sad_idx;
  logic [SW-1:0] best_sad;
  logic [IW-1:0] best_idx;
  logic          busy;
  logic          done;

  modport master (
    input  start, afd_sad,
    output mem_rd, addr_orig, addr_cand, afd_en, afd_acum,
           sad_valid, sad_value, sad_idx, best_sad, best_idx, busy, done
  );

  modport slave (
    output start, afd_sad,
    input  mem_rd, addr_orig, addr_cand, afd_en, afd_acum,
           sad_valid, sad_value, sad_idx, best_sad, best_idx, busy, done
  );

endinterface

// File: rtl/sad_min_tracker.sv
// Running minimum of candidate SADs with the index that produced it;
// strict less-than so the earliest candidate wins a tie.
module sad_min_tracker #(
  parameter int SW = 16,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          update_i,
  input  logic [SW-1:0] sad_i,
  input  logic [IW-1:0] idx_i,
  output logic [SW-1:0] best_sad_o,
  output logic [IW-1:0] best_idx_o
);

  logic [SW-1:0] best_sad_q, best_sad_d;
  logic [IW-1:0] best_idx_q, best_idx_d;

  always_comb begin
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;
    if (clear_i) begin
      best_sad_d = '1;
      best_idx_d = '0;
    end else if (update_i && (sad_i < best_sad_q)) begin
      best_sad_d = sad_i;
      best_idx_d = idx_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      best_sad_q <= '1;
      best_idx_q <= '0;
    end else begin
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
    end
  end

  assign best_sad_o = best_sad_q;
  assign best_idx_o = best_idx_q;

endmodule

// File: rtl/sad_search_ctrl.sv
// Sequencer for block-matching motion search: issues pair reads per
// candidate, steers the afd accumulator and tracks the best candidate.
module sad_search_ctrl
  import sad_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int N_PAIRS = 8,
  parameter int N_CAND  = 4
) (
  input logic               clk,
  input logic               rst,
  sad_search_ctrl_if.master bus
);

  localparam int SW = sad_width(WIDTH);
  localparam int OW = idx_width(N_PAIRS);
  localparam int CW = idx_width(N_CAND * N_PAIRS);
  localparam int IW = idx_width(N_CAND);
  localparam int DW = idx_width(AFD_LAT);

  sad_state_e    state_q, state_d;
  logic [OW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] cand_q, cand_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          afd_en_q, afd_acum_q;
  logic          mem_rd, sad_valid, done, clear, update;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    drain_d   = drain_q;
    mem_rd    = 1'b0;
    sad_valid = 1'b0;
    done      = 1'b0;
    clear     = 1'b0;
    update    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ISSUE;
          cnt_d   = '0;
          cand_d  = '0;
          drain_d = '0;
          clear   = 1'b1;
        end
      end
      ISSUE: begin
        mem_rd = 1'b1;
        if (cnt_q == OW'(N_PAIRS - 1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
          drain_d = '0;
        end else begin
          cnt_d = cnt_q + OW'(1);
        end
      end
      DRAIN: begin
        if (drain_q == DW'(AFD_LAT - 1)) begin
          state_d = COMPARE;
          drain_d = '0;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      COMPARE: begin
        sad_valid = 1'b1;
        update    = 1'b1;
        if (cand_q == IW'(N_CAND - 1)) begin
          state_d = DONE;
        end else begin
          cand_d  = cand_q + IW'(1);
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // afd_en/afd_acum ride one register behind the read strobe so they meet
  // the synchronous-read data; the first pair of each candidate loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cand_q     <= '0;
      drain_q    <= '0;
      afd_en_q   <= 1'b0;
      afd_acum_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      drain_q    <= drain_d;
      afd_en_q   <= mem_rd;
      afd_acum_q <= mem_rd & (cnt_q != '0);
    end
  end

  sad_min_tracker #(
    .SW(SW),
    .IW(IW)
  ) u_min_tracker (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (clear),
    .update_i  (update),
    .sad_i     (bus.afd_sad),
    .idx_i     (cand_q),
    .best_sad_o(bus.best_sad),
    .best_idx_o(bus.best_idx)
  );

  assign bus.mem_rd    = mem_rd;
  assign bus.addr_orig = cnt_q;
  assign bus.addr_cand = CW'(cand_q) * CW'(N_PAIRS) + CW'(cnt_q);
  assign bus.afd_en    = afd_en_q;
  assign bus.afd_acum  = afd_acum_q;
  assign bus.sad_valid = sad_valid;
  assign bus.sad_value = sad_valid ? bus.afd_sad : '0;
  assign bus.sad_idx   = sad_valid ? cand_q : '0;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Bench for sad_search_ctrl: memory and afd models feed the search, a
// scoreboard holds the expected sad_valid/done events of each search.
module tb_sad_search_ctrl;
  import sad_pkg::*;

  localparam int WIDTH = 8;
  localparam int NP    = 8;
  localparam int NC    = 4;
  localparam int SW    = sad_width(WIDTH);
  localparam logic [31:0] ALL_ONES = 32'((33'd1 << SW) - 1);

  typedef struct {
    int          cyc;
    logic [SW-1:0] val;
    int          idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   testsRun = 0;
  int   testsFailed = 0;
  bit   monOn = 1'b0;
  int   tgt[NC];
  exp_t sadQ[$];
  exp_t doneQ[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sad_search_ctrl_if #(.WIDTH(WIDTH), .N_PAIRS(NP), .N_CAND(NC)) bus ();
  sad_search_ctrl_if #(.WIDTH(WIDTH), .N_PAIRS(2), .N_CAND(1)) bus2 ();

  sad_search_ctrl #(.WIDTH(WIDTH), .N_PAIRS(NP), .N_CAND(NC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  sad_search_ctrl #(.WIDTH(WIDTH), .N_PAIRS(2), .N_CAND(1)) dut2 (
    .clk(clk),
    .rst(rst),
    .bus(bus2.master)
  );

  // Memory and two-stage afd models (input register, then accumulator).
  logic [2*WIDTH-1:0] origMem[NP];
  logic [2*WIDTH-1:0] candMem[NC*NP];
  logic [2*WIDTH-1:0] origRd = '0, candRd = '0;
  logic [SW-1:0]      acc = '0;
  int                 d1 = 0;
  logic               en1 = 1'b0, acum1 = 1'b0;

  function automatic int absDiff(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a > b) ? int'(a) - int'(b) : int'(b) - int'(a);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_rd === 1'b1) begin
      origRd <= origMem[bus.addr_orig];
      candRd <= candMem[bus.addr_cand];
    end
    en1   <= bus.afd_en;
    acum1 <= bus.afd_acum;
    d1    <= absDiff(origRd[7:0], candRd[7:0]) + absDiff(origRd[15:8], candRd[15:8]);
    if (en1) acc <= acum1 ? acc + SW'(d1) : SW'(d1);
  end

  assign bus.afd_sad  = acc;
  assign bus2.afd_sad = SW'(123);

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (monOn) begin
      if (sadQ.size() != 0 && sadQ[0].cyc == cyc) begin
        e = sadQ.pop_front();
        checkOutput("sad_valid", 32'(bus.sad_valid), 1);
        checkOutput("sad_value", 32'(bus.sad_value), 32'(e.val));
        checkOutput("sad_idx", 32'(bus.sad_idx), e.idx);
      end else if (bus.sad_valid !== 1'b0) begin
        checkOutput("sad_valid stray", 32'(bus.sad_valid), 0);
      end
      if (doneQ.size() != 0 && doneQ[0].cyc == cyc) begin
        e = doneQ.pop_front();
        checkOutput("done", 32'(bus.done), 1);
        checkOutput("best_sad", 32'(bus.best_sad), 32'(e.val));
        checkOutput("best_idx", 32'(bus.best_idx), e.idx);
      end else if (bus.done !== 1'b0) begin
        checkOutput("done stray", 32'(bus.done), 0);
      end
    end
  end

  // Each candidate's pixel differences sum exactly to its target SAD.
  task automatic loadMem();
    for (int k = 0; k < NP; k++)
      for (int p = 0; p < 2; p++)
        origMem[k][8*p +: 8] = 8'(60 + ((k * 2 + p) * 13) % 90);
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < NP; k++)
        for (int p = 0; p < 2; p++)
          candMem[c*NP+k][8*p +: 8] = origMem[k][8*p +: 8] +
            8'(tgt[c] / (2 * NP) + ((k == 0 && p == 0) ? tgt[c] % (2 * NP) : 0));
  endtask

  task automatic pushSearch(input int t0, input int nCand, input bit withDone);
    exp_t e;
    logic [SW-1:0] best = '1;
    int bi = 0;
    for (int c = 0; c < nCand; c++) begin
      e.cyc = t0 + (c + 1) * (NP + 3);
      e.val = SW'(tgt[c]);
      e.idx = c;
      sadQ.push_back(e);
      if (SW'(tgt[c]) < best) begin
        best = SW'(tgt[c]);
        bi   = c;
      end
    end
    if (withDone) begin
      e.cyc = t0 + NC * (NP + 3) + 1;
      e.val = best;
      e.idx = bi;
      doneQ.push_back(e);
    end
  endtask

  task automatic stepTo(input int t0, input int rel);
    while (cyc - t0 < rel) @(negedge clk);
  endtask

  task automatic applyStimulus(input int t0, input int rel);
    stepTo(t0, rel);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    int t0;
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus2.start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset mem_rd", 32'(bus.mem_rd), 0);
    checkOutput("reset afd_en", 32'(bus.afd_en), 0);
    checkOutput("reset busy", 32'(bus.busy), 0);
    checkOutput("reset done", 32'(bus.done), 0);
    checkOutput("reset sad_valid", 32'(bus.sad_valid), 0);
    checkOutput("reset best_sad", 32'(bus.best_sad), ALL_ONES);
    checkOutput("reset best_idx", 32'(bus.best_idx), 0);
    rst = 1'b0;
    monOn = 1'b1;
    @(negedge clk);

    // Mixed SADs with a tie, plus the address/enable trace of candidate 2.
    tgt = '{400, 96, 200, 96};
    loadMem();
    t0 = cyc;
    pushSearch(t0, NC, 1'b1);
    applyStimulus(t0, 0);
    for (int rel = 1; rel <= 46; rel++) begin
      stepTo(t0, rel);
      if (rel >= 23 && rel <= 30) begin
        checkOutput("trace mem_rd", 32'(bus.mem_rd), 1);
        checkOutput("trace addr_cand", 32'(bus.addr_cand), 16 + rel - 23);
        checkOutput("trace addr_orig", 32'(bus.addr_orig), rel - 23);
      end
      if (rel >= 24 && rel <= 31) begin
        checkOutput("trace afd_en", 32'(bus.afd_en), 1);
        checkOutput("trace afd_acum", 32'(bus.afd_acum), 32'(rel != 24));
      end
      if (rel == 31) checkOutput("trace mem_rd off", 32'(bus.mem_rd), 0);
      if (rel == 32) checkOutput("trace afd_en off", 32'(bus.afd_en), 0);
      if (rel == 45) checkOutput("busy in DONE", 32'(bus.busy), 1);
      if (rel == 46) checkOutput("idle after DONE", 32'(bus.busy), 0);
    end

    // All-zero SADs, then an immediate second search clears best.
    tgt = '{0, 0, 0, 0};
    loadMem();
    t0 = cyc;
    pushSearch(t0, NC, 1'b1);
    applyStimulus(t0, 0);
    stepTo(t0, 45);
    pushSearch(t0 + 46, NC, 1'b1);
    applyStimulus(t0, 46);
    stepTo(t0, 48);
    checkOutput("best cleared on start", 32'(bus.best_sad), ALL_ONES);
    stepTo(t0, 93);

    // Starts while busy and in DONE are ignored; the one after DONE runs.
    tgt = '{300, 500, 100, 100};
    loadMem();
    t0 = cyc;
    pushSearch(t0, NC, 1'b1);
    applyStimulus(t0, 0);
    applyStimulus(t0, 5);
    applyStimulus(t0, 11);
    applyStimulus(t0, 45);
    pushSearch(t0 + 46, NC, 1'b1);
    applyStimulus(t0, 46);
    stepTo(t0, 93);

    // Reset mid-search aborts; a later start runs a complete search.
    tgt = '{250, 50, 150, 75};
    loadMem();
    t0 = cyc;
    pushSearch(t0, 1, 1'b0);
    applyStimulus(t0, 0);
    stepTo(t0, 15);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort mem_rd", 32'(bus.mem_rd), 0);
    checkOutput("abort afd_en", 32'(bus.afd_en), 0);
    checkOutput("abort busy", 32'(bus.busy), 0);
    checkOutput("abort best_sad", 32'(bus.best_sad), ALL_ONES);
    checkOutput("abort best_idx", 32'(bus.best_idx), 0);
    pushSearch(t0 + 20, NC, 1'b1);
    applyStimulus(t0, 20);
    stepTo(t0, 67);

    // Minimal geometry: two pairs, one candidate.
    @(negedge clk);
    t0 = cyc;
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    for (int rel = 1; rel <= 7; rel++) begin
      stepTo(t0, rel);
      checkOutput("small sad_valid", 32'(bus2.sad_valid), 32'(rel == 5));
      checkOutput("small done", 32'(bus2.done), 32'(rel == 6));
      if (rel == 5) checkOutput("small sad_value", 32'(bus2.sad_value), 123);
      if (rel == 6) begin
        checkOutput("small best_sad", 32'(bus2.best_sad), 123);
        checkOutput("small best_idx", 32'(bus2.best_idx), 0);
      end
    end

    checkOutput("sad events pending", sadQ.size(), 0);
    checkOutput("done events pending", doneQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
